exe_stage_pipe: RTL and testbench

//  Parametrised, handshaked execute stage for the ARM pipeline: Val2 generation, ALU, branch target and

---
 rtl/exe_pkg.sv | 36 +++
 rtl/exe_mul_iter.sv | 60 ++++++
 rtl/exe_stage_pipe.sv | 211 +++++++++++++++++++++
 tb/tb_exe_stage_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command encodings,
// shifter type codes, NZCV bit positions and the stage FSM state type.
package exe_pkg;

    // ALU commands (CMP shares SUB, TST shares AND; loads/stores use ADD)
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;
    localparam logic [3:0] CMD_CMP = CMD_SUB;
    localparam logic [3:0] CMD_TST = CMD_AND;

    // Register-operand shift types (shift_op[6:5])
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Bit positions inside a 4-bit NZCV vector
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exe_state_e;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// done is asserted combinationally during the final iteration, with
// result already holding the completed product for that edge.
module exe_mul_iter #(
    parameter int DATA_W    = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    localparam int CNT_W = $clog2(MUL_ITERS);

    logic [DATA_W-1:0] mcand_reg;
    logic [DATA_W-1:0] mplier_reg;
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    assign busy     = busy_reg;
    assign done     = busy_reg && (cnt_reg == CNT_W'(MUL_ITERS - 1));
    assign result   = acc_next;

    // Load operands on start, then add-and-shift until the last iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
        end else if (abort) begin
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            mcand_reg  <= a;
            mplier_reg <= b;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exe_stage_pipe.sv
// Handshaked execute stage: Val2 generation, ALU, branch target and the
// registered EXE->MEM entry. Define EXE_MUL_EN to add the iterative
// multiplier; without it CMD_MUL behaves as an undefined command.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IMM_W     = 24,
    parameter int MUL_ITERS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        exe_cmd,
    input  logic              s_bit,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic              imm,
    input  logic [11:0]       shift_op,
    input  logic [IMM_W-1:0]  signed_imm,
    input  logic [3:0]        sr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] br_addr,
    output logic [3:0]        status,
    output logic              status_we,
    output logic              mem_r_en_o,
    output logic              mem_w_en_o,
    output logic [DATA_W-1:0] st_data
);
    localparam int MSB = DATA_W - 1;

    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] v, input logic [4:0] amt);
        logic [2*DATA_W-1:0] dbl;
        dbl = {v, v} >> (32'(amt) % DATA_W);
        return dbl[DATA_W-1:0];
    endfunction

    logic              idle;
    logic              is_mul;
    logic              mul_done;
    logic [DATA_W-1:0] mul_result;
    logic              accept;

    logic              out_valid_reg;
    logic [DATA_W-1:0] alu_result_reg;
    logic [DATA_W-1:0] br_addr_reg;
    logic [3:0]        status_reg;
    logic              status_we_reg;
    logic              mem_r_en_reg;
    logic              mem_w_en_reg;
    logic [DATA_W-1:0] st_data_reg;

    logic [DATA_W-1:0] val2;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        alu_nzcv;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              cin;
    logic              arith;
    logic              logic_op;

    // A flush in the same cycle discards whatever would have been accepted
    assign in_ready = rst && idle && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready && !flush;

`ifdef EXE_MUL_EN
    exe_state_e state_reg;
    logic       mul_busy;

    assign idle   = (state_reg == ST_IDLE);
    assign is_mul = (exe_cmd == CMD_MUL);

    exe_mul_iter #(
        .DATA_W    (DATA_W),
        .MUL_ITERS (MUL_ITERS)
    ) u_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_mul),
        .abort  (flush),
        .a      (val_rn),
        .b      (val_rm),
        .busy   (mul_busy),
        .done   (mul_done),
        .result (mul_result)
    );

    // Stage FSM: park in MUL while the multiplier iterates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else if (flush) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept && is_mul) state_reg <= ST_MUL;
                ST_MUL:  if (mul_busy && mul_done) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    assign idle       = 1'b1;
    assign is_mul     = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    // Second operand: memory offset, rotated immediate or shifted Rm
    always_comb begin
        val2 = '0;
        if (mem_r_en || mem_w_en) begin
            val2 = DATA_W'(shift_op);
        end else if (imm) begin
            val2 = ror(DATA_W'(shift_op[7:0]), {shift_op[11:8], 1'b0});
        end else begin
            case (shift_op[6:5])
                SH_LSL:  val2 = val_rm << shift_op[11:7];
                SH_LSR:  val2 = val_rm >> shift_op[11:7];
                SH_ASR:  val2 = $unsigned($signed(val_rm) >>> shift_op[11:7]);
                default: val2 = ror(val_rm, shift_op[11:7]);
            endcase
        end
    end

    // ALU: one shared adder for add/sub forms; subtraction adds ~val2 + carry
    always_comb begin
        alu_res  = '0;
        alu_nzcv = sr;
        b_eff    = val2;
        cin      = 1'b0;
        arith    = 1'b0;
        logic_op = 1'b0;
        case (exe_cmd)
            CMD_MOV: begin alu_res = val2;          logic_op = 1'b1; end
            CMD_MVN: begin alu_res = ~val2;         logic_op = 1'b1; end
            CMD_AND: begin alu_res = val_rn & val2; logic_op = 1'b1; end
            CMD_ORR: begin alu_res = val_rn | val2; logic_op = 1'b1; end
            CMD_EOR: begin alu_res = val_rn ^ val2; logic_op = 1'b1; end
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = sr[NZCV_C]; end
            CMD_SUB: begin arith = 1'b1; b_eff = ~val2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; b_eff = ~val2; cin = sr[NZCV_C]; end
            default: ;
        endcase
        sum = {1'b0, val_rn} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
        if (arith) begin
            alu_res  = sum[MSB:0];
            alu_nzcv = {sum[MSB], (sum[MSB:0] == '0), sum[DATA_W],
                        (val_rn[MSB] == b_eff[MSB]) && (sum[MSB] != val_rn[MSB])};
        end else if (logic_op) begin
            alu_nzcv = {alu_res[MSB], (alu_res == '0), 2'b00};
        end
    end

    // Output entry: flush kills it, multiply completion or accept loads it,
    // and it empties when drained with nothing new arriving
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg  <= 1'b0;
            alu_result_reg <= '0;
            br_addr_reg    <= '0;
            status_reg     <= '0;
            status_we_reg  <= 1'b0;
            mem_r_en_reg   <= 1'b0;
            mem_w_en_reg   <= 1'b0;
            st_data_reg    <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (mul_done) begin
            alu_result_reg <= mul_result;
            status_reg[NZCV_N] <= mul_result[MSB];
            status_reg[NZCV_Z] <= (mul_result == '0);
            out_valid_reg  <= 1'b1;
        end else if (accept) begin
            br_addr_reg   <= pc + (DATA_W'($signed(signed_imm)) << 2);
            status_we_reg <= s_bit;
            mem_r_en_reg  <= mem_r_en;
            mem_w_en_reg  <= mem_w_en;
            st_data_reg   <= val_rm;
            if (is_mul) begin
                // C and V of a multiply come from the flags seen at accept
                status_reg[1:0] <= sr[1:0];
                out_valid_reg   <= 1'b0;
            end else begin
                alu_result_reg <= alu_res;
                status_reg     <= alu_nzcv;
                out_valid_reg  <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign alu_result = alu_result_reg;
    assign br_addr    = br_addr_reg;
    assign status     = status_reg;
    assign status_we  = status_we_reg;
    assign mem_r_en_o = mem_r_en_reg;
    assign mem_w_en_o = mem_w_en_reg;
    assign st_data    = st_data_reg;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe (default 32-bit configuration).
// Multiply expectations follow whether EXE_MUL_EN is defined for the build.
module tb_exe_stage_pipe;

    localparam logic [3:0] C_MOV = 4'b0001, C_ADD = 4'b0010, C_ADC = 4'b0011,
                           C_SUB = 4'b0100, C_EOR = 4'b1000, C_MUL = 4'b1010,
                           C_UND = 4'b1111;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [3:0]  exe_cmd;
    logic        s_bit, mem_r_en, mem_w_en, imm;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_op;
    logic [23:0] signed_imm;
    logic [3:0]  sr;
    logic        out_valid, out_ready;
    logic [31:0] alu_result, br_addr, st_data;
    logic [3:0]  status;
    logic        status_we, mem_r_en_o, mem_w_en_o;

    int total = 0;
    int bad   = 0;

    exe_stage_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exe_cmd    (exe_cmd),
        .s_bit      (s_bit),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .pc         (pc),
        .val_rn     (val_rn),
        .val_rm     (val_rm),
        .imm        (imm),
        .shift_op   (shift_op),
        .signed_imm (signed_imm),
        .sr         (sr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .br_addr    (br_addr),
        .status     (status),
        .status_we  (status_we),
        .mem_r_en_o (mem_r_en_o),
        .mem_w_en_o (mem_w_en_o),
        .st_data    (st_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic im, input logic [11:0] sop, input logic [3:0] srv);
        in_valid = 1'b1; exe_cmd = cmd; val_rn = rn; val_rm = rm; imm = im;
        shift_op = sop; sr = srv; s_bit = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0;
        pc = 32'h0; signed_imm = 24'h0;
    endtask

    initial begin
        bit early;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(4'h0, 32'h0, 32'h0, 1'b0, 12'h0, 4'h0);
        in_valid = 1'b0;
        repeat (2) tick();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", alu_result, 32'h0);
        chk("rst_status", 32'(status), 32'h0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'h1);

        // ADD with immediate 1 overflows into the sign bit
        drive(C_ADD, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 4'h0);
        chk("add_pre_valid", 32'(out_valid), 32'h0);
        tick();
        chk("add_valid", 32'(out_valid), 32'h1);
        chk("add_result", alu_result, 32'h8000_0000);
        chk("add_nzcv", 32'(status), 32'h9);
        chk("add_status_we", 32'(status_we), 32'h1);

        // SUB equal operands, then ADC with carry in
        drive(C_SUB, 32'h5, 32'h5, 1'b0, 12'h000, 4'h0);
        tick();
        chk("sub_result", alu_result, 32'h0);
        chk("sub_nzcv", 32'(status), 32'h6);
        drive(C_ADC, 32'h1, 32'h1, 1'b0, 12'h000, 4'b0010);
        tick();
        chk("adc_result", alu_result, 32'h3);
        chk("adc_nzcv", 32'(status), 32'h0);

        // MOV with ASR #4 and MOV of 0xFF rotated right by 8
        drive(C_MOV, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 4'h0);
        tick();
        chk("mov_asr", alu_result, 32'hF800_0000);
        chk("mov_asr_nzcv", 32'(status), 32'h8);
        drive(C_MOV, 32'h0, 32'h0, 1'b1, 12'h4FF, 4'h0);
        tick();
        chk("mov_rot_imm", alu_result, 32'hFF00_0000);

        // Backpressure: entry holds, input stalls, next op drains on release
        drive(C_ADD, 32'h10, 32'h0, 1'b1, 12'h005, 4'h0);
        tick();
        out_ready = 1'b0;
        drive(C_EOR, 32'hF0, 32'h0, 1'b1, 12'h0FF, 4'h0);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        repeat (3) tick();
        chk("bp_hold_valid", 32'(out_valid), 32'h1);
        chk("bp_hold_result", alu_result, 32'h15);
        chk("bp_stall_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(in_ready), 32'h1);
        tick();
        chk("bp_next_result", alu_result, 32'h0F);
        chk("bp_next_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Load address generation plus branch target and store data
        drive(C_ADD, 32'h1000, 32'hDEAD, 1'b0, 12'h00C, 4'h0);
        mem_r_en = 1'b1; pc = 32'h100; signed_imm = 24'hFFFFFE;
        tick();
        chk("ldr_addr", alu_result, 32'h100C);
        chk("ldr_mem_r", 32'(mem_r_en_o), 32'h1);
        chk("br_addr", br_addr, 32'hF8);
        chk("st_data", st_data, 32'hDEAD);

        // Undefined command leaves the flags untouched
        drive(C_UND, 32'h1234, 32'h1, 1'b0, 12'h000, 4'b1010);
        tick();
        chk("undef_result", alu_result, 32'h0);
        chk("undef_status", 32'(status), 32'hA);
        in_valid = 1'b0;
        tick();

        // Multiply 0xFFFF * 0x10001
        drive(C_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b0, 12'h000, 4'b0011);
`ifdef EXE_MUL_EN
        tick();
        in_valid = 1'b0;
        chk("mul_busy_ready", 32'(in_ready), 32'h0);
        early = 1'b0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        chk("mul_no_early", 32'(early), 32'h0);
        tick();
        chk("mul_valid", 32'(out_valid), 32'h1);
        chk("mul_result", alu_result, 32'hFFFF_FFFF);
        chk("mul_nzcv", 32'(status), 32'hB);
        tick();

        // Flush during multiply cycle 10 abandons it
        drive(C_MUL, 32'h3, 32'h3, 1'b0, 12'h000, 4'h0);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("mflush_valid", 32'(out_valid), 32'h0);
        chk("mflush_ready", 32'(in_ready), 32'h1);
        early = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        chk("mflush_silent", 32'(early), 32'h0);
`else
        tick();
        in_valid = 1'b0;
        chk("mul_off_valid", 32'(out_valid), 32'h1);
        chk("mul_off_result", alu_result, 32'h0);
        chk("mul_off_status", 32'(status), 32'h3);
        tick();
`endif

        // Flush with a same-cycle accept emits nothing
        drive(C_ADD, 32'h1, 32'h1, 1'b0, 12'h000, 4'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_accept", 32'(out_valid), 32'h0);

        // Flush kills a stalled entry
        drive(C_ADD, 32'h2, 32'h2, 1'b0, 12'h000, 4'h0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("stall_valid", 32'(out_valid), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_entry", 32'(out_valid), 32'h0);

        // Asynchronous reset while an entry is valid
        drive(C_ADD, 32'h20, 32'h0, 1'b1, 12'h001, 4'h0);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_result", alu_result, 32'h0);
        chk("arst_ready", 32'(in_ready), 32'h0);
        tick();
        rst = 1'b1;

`ifdef EXE_MUL_EN
        // Reset mid-multiply: no output afterwards
        drive(C_MUL, 32'h5, 32'h7, 1'b0, 12'h000, 4'h0);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        chk("mrst_silent", 32'(early), 32'h0);
        chk("mrst_ready", 32'(in_ready), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
